// File: rtl/pipe_core_p.sv
// pipe_core_p: four-stage (IF, ID, EX, WB) 8-bit-instruction pipeline with
// an eight-entry register file, jump resolution in fetch, write-through on
// the register read in ID and forwarding from EX/WB into EX, so no stalls.
module pipe_core_p #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [5:0]        imem_addr,
  input  logic [7:0]        imem_data,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wb_valid,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  logic [5:0]        pc;
  logic              ifid_valid;
  logic [7:0]        ifid_instr;
  logic              idex_valid;
  logic [1:0]        idex_op;
  logic [2:0]        idex_rd;
  logic [2:0]        idex_rs;
  logic [DATA_W-1:0] idex_a;
  logic [DATA_W-1:0] idex_b;
  logic              exwb_valid;
  logic [2:0]        exwb_addr;
  logic [DATA_W-1:0] exwb_data;
  logic [DATA_W-1:0] regfile [8];

  logic              if_is_jmp;
  logic [1:0]        id_op;
  logic [2:0]        id_rd;
  logic [2:0]        id_rs;
  logic [DATA_W-1:0] id_rd_val;
  logic [DATA_W-1:0] id_b_val;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_res;

  assign imem_addr  = pc;
  assign wb_valid   = exwb_valid;
  assign wb_addr    = exwb_addr;
  assign wb_data    = exwb_data;
  assign if_is_jmp  = (imem_data[7:6] == OP_JMP);
  assign id_op      = ifid_instr[7:6];
  assign id_rd      = ifid_instr[5:3];
  assign id_rs      = ifid_instr[2:0];

  // Debug port sees the value the register is about to take this edge
  assign dbg_data = (exwb_valid && exwb_addr == dbg_addr) ? exwb_data : regfile[dbg_addr];

  // Fetch: a jump redirects the PC immediately and leaves a bubble behind
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= '0;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
    end else if (run) begin
      if (if_is_jmp) begin
        pc         <= imem_data[5:0];
        ifid_valid <= 1'b0;
      end else begin
        pc         <= pc + 6'd1;
        ifid_valid <= 1'b1;
      end
      ifid_instr <= imem_data;
    end
  end

  // Decode operand read with write-through from the instruction in WB
  always_comb begin
    id_rd_val = regfile[id_rd];
    id_b_val  = regfile[id_rs];
    if (exwb_valid && exwb_addr == id_rd) id_rd_val = exwb_data;
    if (id_op == OP_LDI) begin
      id_b_val = {{(DATA_W-3){ifid_instr[2]}}, ifid_instr[2:0]};
    end else if (exwb_valid && exwb_addr == id_rs) begin
      id_b_val = exwb_data;
    end
  end

  // ID/EX register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_valid <= 1'b0;
      idex_op    <= '0;
      idex_rd    <= '0;
      idex_rs    <= '0;
      idex_a     <= '0;
      idex_b     <= '0;
    end else if (run) begin
      idex_valid <= ifid_valid;
      idex_op    <= id_op;
      idex_rd    <= id_rd;
      idex_rs    <= id_rs;
      idex_a     <= id_rd_val;
      idex_b     <= id_b_val;
    end
  end

  // Execute with forwarding from the result now sitting in EX/WB
  always_comb begin
    ex_a = idex_a;
    ex_b = idex_b;
    if (exwb_valid && exwb_addr == idex_rd) ex_a = exwb_data;
    if (idex_op != OP_LDI && exwb_valid && exwb_addr == idex_rs) ex_b = exwb_data;
    case (idex_op)
      OP_ADD:  ex_res = ex_a + ex_b;
      OP_SUB:  ex_res = ex_a - ex_b;
      default: ex_res = ex_b;
    endcase
  end

  // EX/WB register; every instruction that reaches EX writes a register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exwb_valid <= 1'b0;
      exwb_addr  <= '0;
      exwb_data  <= '0;
    end else if (run) begin
      exwb_valid <= idex_valid;
      exwb_addr  <= idex_rd;
      exwb_data  <= ex_res;
    end
  end

  // Register file write from WB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regfile[i] <= '0;
    end else if (run && exwb_valid) begin
      regfile[exwb_addr] <= exwb_data;
    end
  end

  // Saturating count of retired register writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt <= '0;
    end else if (run && exwb_valid && retire_cnt != {CNT_W{1'b1}}) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_core_p.sv
// tb_pipe_core_p: directed programs for pipe_core_p. Expected write-backs
// are queued when each program is loaded; a negedge monitor pops and compares
// them as the DUT retires. A second instance (DATA_W=16, CNT_W=2) runs the same
// programs for width and counter-saturation checks.
module tb_pipe_core_p;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [2:0]  dbg_addr = '0;
  logic [7:0]  mem [64];

  logic [5:0]  imem_addr;
  logic [7:0]  imem_data;
  logic [7:0]  dbg_data;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic [15:0] retire_cnt;

  logic [5:0]  w_imem_addr;
  logic [7:0]  w_imem_data;
  logic [15:0] w_dbg_data;
  logic        w_wb_valid;
  logic [2:0]  w_wb_addr;
  logic [15:0] w_wb_data;
  logic [1:0]  w_retire_cnt;

  wb_exp_t     exp_q [$];
  wb_exp_t     mon_e;
  int          vectors = 0;
  int          miscompares = 0;

  assign imem_data   = mem[imem_addr];
  assign w_imem_data = mem[w_imem_addr];

  pipe_core_p #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .retire_cnt(retire_cnt)
  );

  pipe_core_p #(.DATA_W(16), .CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .run(run),
    .imem_addr(w_imem_addr), .imem_data(w_imem_data),
    .dbg_addr(dbg_addr), .dbg_data(w_dbg_data),
    .wb_valid(w_wb_valid), .wb_addr(w_wb_addr), .wb_data(w_wb_data),
    .retire_cnt(w_retire_cnt)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 2 ns past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_reg(input string name, input logic [2:0] r, input logic [7:0] exp);
    dbg_addr = r;
    #1;
    check_output(name, dbg_data, exp);
  endtask

  // Hold reset, fill memory with jump-to-self halts, then place a program
  task automatic apply_stimulus(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
    reset = 1'b1;
    run   = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) mem[i] = 8'h80 | 8'(i);
    mem[0] = a0;
    mem[1] = a1;
    mem[2] = a2;
    step(1);
  endtask

  task automatic release_reset();
    reset = 1'b0;
    run   = 1'b1;
    #1;
    check_output("fetch_start", imem_addr, 6'd0);
  endtask

  // Scoreboard monitor: a write-back that will commit on the next edge
  always @(negedge clk) begin
    if (!reset && run && wb_valid) begin
      if (exp_q.size() == 0) begin
        check_output("wb_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("wb_addr", wb_addr, mon_e.addr);
        check_output("wb_data", wb_data, mon_e.data);
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h80 | 8'(i);

    // Reset state
    step(2);
    check_output("rst_imem_addr", imem_addr, 0);
    check_output("rst_wb_valid", wb_valid, 0);
    check_output("rst_wb_addr", wb_addr, 0);
    check_output("rst_wb_data", wb_data, 0);
    check_output("rst_retire", retire_cnt, 0);
    for (int r = 0; r < 8; r++) check_reg("rst_reg", 3'(r), 8'h00);

    // Hazards: LDI r1,3; LDI r2,-1; ADD r1,r2
    apply_stimulus(8'h4B, 8'h57, 8'h0A);
    exp_q.push_back('{3'd1, 8'h03});
    exp_q.push_back('{3'd2, 8'hFF});
    exp_q.push_back('{3'd1, 8'h02});
    release_reset();
    step(1);
    check_output("haz_imem_addr1", imem_addr, 6'd1);
    step(4);
    check_output("haz_wb_valid", wb_valid, 1);
    check_output("haz_wb_addr", wb_addr, 3'd1);
    check_output("haz_wb_data", wb_data, 8'h02);
    check_output("haz_w16_wb_data", w_wb_data, 16'h0002);
    step(1);
    check_reg("haz_r1", 3'd1, 8'h02);
    check_reg("haz_r2", 3'd2, 8'hFF);
    check_output("haz_w16_r2", w_dbg_data, 16'hFFFF);
    check_output("haz_retire", retire_cnt, 3);
    step(3);
    check_output("haz_retire_hold", retire_cnt, 3);
    check_output("haz_queue_empty", exp_q.size(), 0);

    // Jump: JMP 5 skips the LDI r3 at address 1; LDI r4,2 at 5
    apply_stimulus(8'h85, 8'h59, 8'h82);
    mem[5] = 8'h62;
    exp_q.push_back('{3'd4, 8'h02});
    release_reset();
    step(1);
    check_output("jmp_imem_5", imem_addr, 6'd5);
    step(1);
    check_output("jmp_imem_6", imem_addr, 6'd6);
    step(1);
    check_output("jmp_imem_halt", imem_addr, 6'd6);
    step(4);
    check_reg("jmp_r3", 3'd3, 8'h00);
    check_reg("jmp_r4", 3'd4, 8'h02);
    check_output("jmp_retire", retire_cnt, 1);
    check_output("jmp_queue_empty", exp_q.size(), 0);

    // SUB wrap: LDI r1,-4; LDI r2,3; SUB r1,r2 -> -7
    apply_stimulus(8'h4C, 8'h53, 8'hCA);
    exp_q.push_back('{3'd1, 8'hFC});
    exp_q.push_back('{3'd2, 8'h03});
    exp_q.push_back('{3'd1, 8'hF9});
    release_reset();
    step(8);
    check_reg("sub_r1", 3'd1, 8'hF9);
    check_output("sub_w16_r1", w_dbg_data, 16'hFFF9);
    check_reg("sub_r2", 3'd2, 8'h03);
    check_output("sub_retire", retire_cnt, 3);
    check_output("sub_queue_empty", exp_q.size(), 0);

    // Stall: hazard program paused for 4 cycles with a corrupted fetch word
    apply_stimulus(8'h4B, 8'h57, 8'h0A);
    exp_q.push_back('{3'd1, 8'h03});
    exp_q.push_back('{3'd2, 8'hFF});
    exp_q.push_back('{3'd1, 8'h02});
    release_reset();
    step(3);
    run = 1'b0;
    mem[3] = 8'h85;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_output("stall_imem_addr", imem_addr, 6'd3);
      check_output("stall_wb_valid", wb_valid, 1);
      check_output("stall_wb_addr", wb_addr, 3'd1);
      check_output("stall_wb_data", wb_data, 8'h03);
      check_output("stall_retire", retire_cnt, 0);
    end
    mem[3] = 8'h83;
    run = 1'b1;
    step(5);
    check_reg("stall_r1", 3'd1, 8'h02);
    check_reg("stall_r2", 3'd2, 8'hFF);
    check_output("stall_retire_final", retire_cnt, 3);
    check_output("stall_queue_empty", exp_q.size(), 0);

    // Reset pulse while three instructions are in flight
    apply_stimulus(8'h4B, 8'h57, 8'h0A);
    exp_q.push_back('{3'd1, 8'h03});
    exp_q.push_back('{3'd2, 8'hFF});
    exp_q.push_back('{3'd1, 8'h02});
    release_reset();
    step(3);
    reset = 1'b1;
    #1;
    check_output("mid_rst_imem_addr", imem_addr, 0);
    check_output("mid_rst_wb_valid", wb_valid, 0);
    check_output("mid_rst_wb_addr", wb_addr, 0);
    check_output("mid_rst_wb_data", wb_data, 0);
    exp_q.delete();
    run = 1'b0;
    step(2);
    reset = 1'b0;
    step(3);
    check_output("mid_rst_retire", retire_cnt, 0);
    check_reg("mid_rst_r1", 3'd1, 8'h00);
    check_reg("mid_rst_r2", 3'd2, 8'h00);
    check_output("mid_rst_restart", imem_addr, 0);
    run = 1'b1;
    step(1);
    check_output("mid_rst_next", imem_addr, 6'd1);

    // PC wrap: JMP 61, straight-line LDIs through 63, 0, then halt at 1
    apply_stimulus(8'hBD, 8'h81, 8'h82);
    mem[61] = 8'h71;
    mem[62] = 8'h7A;
    mem[63] = 8'h6B;
    exp_q.push_back('{3'd6, 8'h01});
    exp_q.push_back('{3'd7, 8'h02});
    exp_q.push_back('{3'd5, 8'h03});
    exp_q.push_back('{3'd0, 8'h00});
    release_reset();
    step(1);
    check_output("wrap_imem_61", imem_addr, 6'd61);
    mem[0] = 8'h40;
    step(1);
    check_output("wrap_imem_62", imem_addr, 6'd62);
    step(1);
    check_output("wrap_imem_63", imem_addr, 6'd63);
    step(1);
    check_output("wrap_imem_0", imem_addr, 6'd0);
    step(1);
    check_output("wrap_imem_1", imem_addr, 6'd1);
    step(5);
    check_reg("wrap_r5", 3'd5, 8'h03);
    check_reg("wrap_r7", 3'd7, 8'h02);
    check_output("wrap_retire", retire_cnt, 4);
    check_output("wrap_retire_sat", w_retire_cnt, 2'd3);
    check_output("wrap_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
